// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset pulse, lock wait with timeout/retry, lock qualification and system reset release
//   clock           25 MHz free-running oscillator clock (not the PLL output)
//   reset_n         asynchronous active-low reset
//   locked_in       PLL LOCK, asynchronous to clock
//   pll_rst         PLL RST, active high
//   sys_reset_n     active-low system reset, high only in RUN
//   ready           high only in RUN
//   state           0=RESET_PLL 1=WAIT_LOCK 2=STABLE 3=RUN
//   lock_loss_count saturating count of RUN-to-RESET_PLL transitions
//   retry_count     saturating count of WAIT_LOCK timeouts
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 250000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int CNT_WIDTH           = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 locked_in,
  output logic                 pll_rst,
  output logic                 sys_reset_n,
  output logic                 ready,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] lock_loss_count,
  output logic [CNT_WIDTH-1:0] retry_count
);
  localparam int M1 = PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MX = M1 > LOCK_STABLE_CYCLES ? M1 : LOCK_STABLE_CYCLES;
  localparam int CW = $clog2(MX) + 1;
  typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN} state_t;
  state_t cur, nxt;
  logic sync1, lock_sync, retry_ev, loss_ev;
  logic [CW-1:0] cnt;
  always_comb begin
    nxt = cur;
    retry_ev = 1'b0;
    loss_ev = 1'b0;
    case (cur)
      RESET_PLL: nxt = cnt == CW'(PLL_RST_CYCLES - 1) ? WAIT_LOCK : RESET_PLL;
      WAIT_LOCK: begin
        // a lock seen on the timeout cycle wins over the retry
        retry_ev = !lock_sync && cnt == CW'(LOCK_TIMEOUT_CYCLES - 1);
        nxt = lock_sync ? STABLE : retry_ev ? RESET_PLL : WAIT_LOCK;
      end
      STABLE: nxt = !lock_sync ? WAIT_LOCK : cnt == CW'(LOCK_STABLE_CYCLES - 1) ? RUN : STABLE;
      default: begin
        loss_ev = !lock_sync;
        nxt = loss_ev ? RESET_PLL : RUN;
      end
    endcase
  end
  // outputs are registered from nxt so they change on the same edge as the state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur <= RESET_PLL;
      cnt <= '0;
      sync1 <= 1'b0;
      lock_sync <= 1'b0;
      pll_rst <= 1'b1;
      sys_reset_n <= 1'b0;
      ready <= 1'b0;
      retry_count <= '0;
      lock_loss_count <= '0;
    end else begin
      sync1 <= locked_in;
      lock_sync <= sync1;
      cur <= nxt;
      cnt <= nxt != cur ? '0 : cnt + CW'(1);
      pll_rst <= nxt == RESET_PLL;
      sys_reset_n <= nxt == RUN;
      ready <= nxt == RUN;
      retry_count <= retry_count + CNT_WIDTH'(retry_ev && !(&retry_count));
      lock_loss_count <= lock_loss_count + CNT_WIDTH'(loss_ev && !(&lock_loss_count));
    end
  end
  assign state = cur;
endmodule
